router_port_tx: RTL and testbench
=================================

Name: router_port_tx

Overview:
Output-port serializer for the 8x8 router. It accepts 32-bit payload words from the switch core through a valid/ready handshake and buffers them in a small FIFO. Each word is transmitted on the serial port pins as one packet using the router output protocol: frameo_n/valido_n low together, 32 bits sent LSB first, and frameo_n deasserted on bit 31. One instance drives each of the 8 output ports (dout[k], valido_n[k], frameo_n[k]).

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
MIN_GAP, 1, idle bus cycles between consecutive packets; >= 1

Ports:
clock  input  1  system clock, all logic on posedge
reset_n  input  1  asynchronous active-low reset
wr_valid  input  1  core presents a payload word
wr_data  input  32  payload word; bit 0 is transmitted first
wr_ready  output  1  FIFO can accept; high when fifo_count < DEPTH
dout  output  1  serial data
valido_n  output  1  active-low bit-valid
frameo_n  output  1  active-low frame; high on last bit
pkt_done  output  1  one-cycle pulse during the bit-31 cycle
busy  output  1  high when FIFO is non-empty or the FSM is not IDLE
fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset: clock is `clock`; reset is `reset_n`, asynchronous, active-low. While reset_n is low:
  - dout=0, valido_n=1, frameo_n=1, pkt_done=0.
  - FIFO is emptied; fifo_count=0; busy=0; FSM goes to IDLE.
  - wr_ready=1 once reset is released.
- FIFO write: a word is stored on a posedge where wr_valid && wr_ready. A write while full is impossible because wr_ready=0. wr_data is ignored when wr_valid=0.
- Simultaneous push and pop on the same edge: both take effect and fifo_count is unchanged. A pop never occurs when the FIFO is empty.
- All serial outputs are registered. There is no combinational path from wr_* to dout, valido_n or frameo_n.
- FSM states: IDLE, SHIFT, GAP.
- IDLE:
  - On a posedge with the FIFO non-empty, pop the head word into a 32-bit shift register.
  - On that same edge drive dout=word[0], valido_n=0, frameo_n=0, and go to SHIFT with the bit counter at 0.
  - Latency: a word written at edge T into an empty idle FIFO has bit 0 on the pins after edge T+1.
- SHIFT:
  - Each posedge advances one bit; bit i is on the pins during cycle i of the packet.
  - valido_n=0 for all 32 bits.
  - frameo_n=0 for bits 0..30 and frameo_n=1 for bit 31.
  - pkt_done=1 only during the bit-31 cycle.
  - On the edge that ends bit 31: dout=0, valido_n=1, frameo_n=1, and go to GAP with the gap counter loaded.
- GAP:
  - The bus stays idle for exactly MIN_GAP cycles after the bit-31 cycle.
  - On the edge ending the last gap cycle: if the FIFO is non-empty, pop and drive the next bit 0 (same as IDLE); otherwise go to IDLE.
  - Result: back-to-back packets are separated by exactly MIN_GAP idle cycles.
- Idle bus state is always dout=0, valido_n=1, frameo_n=1.
- Packets are never truncated or interleaved. A push during SHIFT or GAP only fills the FIFO.
- Reset mid-packet: outputs go to the idle state immediately (asynchronously). The partial packet and all queued words are discarded, and nothing is retransmitted after reset is released.
- The counters do not wrap: the bit counter spans 0..31 and the gap counter spans MIN_GAP..1. The FIFO pointers wrap modulo DEPTH.

Test Plan:
- Single word: write 32'hdead_beef into an idle block at edge T. Required:
  - bit 0 (=1) on dout after T+1; valido_n=0 for 32 cycles;
  - frameo_n high only in cycle 31; pkt_done pulses once;
  - a serial receiver captures dead_beef; busy drops after the gap.
- Back-to-back: write 32'h1234_1234 then 32'h0000_1111 on consecutive edges, MIN_GAP=1. Required:
  - two packets in order;
  - exactly 1 idle cycle (valido_n=1, frameo_n=1, dout=0) between the bit-31 cycle and the next bit 0.
- Backpressure, DEPTH=4: hold wr_valid=1 for 8 cycles with distinct words. Required:
  - 5 writes accepted (the first is popped immediately);
  - wr_ready=0 with fifo_count=4;
  - the remaining words are accepted only as packets drain;
  - all words appear on the pins in write order, none lost or duplicated.
- Simultaneous push/pop: with fifo_count=2, push on the edge where the GAP state pops. Required: fifo_count stays 2.
- Reset mid-packet: assert reset_n=0 during bit 10 with 2 words queued. Required:
  - outputs are idle (1/1/0) in the same cycle and fifo_count=0;
  - after release, no valido_n activity for 50 cycles.
- Long gap: MIN_GAP=5 with 3 queued words. Required: 5 idle cycles between each pair of packets; fifo_count decrements at each bit 0.

Source files
------------

// File: rtl/router_port_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_port_tx_if : payload write handshake into a router output port (rev 1.0)
// ---------------------------------------------------------------------------
interface router_port_tx_if;
   logic        wr_valid;
   logic [31:0] wr_data;
   logic        wr_ready;

   modport master (output wr_valid, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/router_port_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_port_tx : FIFO-buffered 32-bit serializer for one router output port (rev 1.0)
// ---------------------------------------------------------------------------
module router_port_tx #(
   parameter int DEPTH   = 4,
   parameter int MIN_GAP = 1
) (
   input  wire logic                  clock,
   input  wire logic                  reset_n,
   router_port_tx_if.slave            wr,
   output logic                       dout,
   output logic                       valido_n,
   output logic                       frameo_n,
   output logic                       pkt_done,
   output logic                       busy,
   output logic [$clog2(DEPTH):0]     fifo_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = $clog2(MIN_GAP + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      GAP   = 2'd2
   } state_t;

   logic [31:0]   fifo_mem [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   state_t        state_q, state_d;
   // Bit 0 goes straight to dout on load, so only bits 31..1 need holding.
   logic [30:0]   shreg_q, shreg_d;
   logic [4:0]    bit_cnt_q, bit_cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic          dout_q, dout_d;
   logic          valido_n_q, valido_n_d;
   logic          frameo_n_q, frameo_n_d;
   logic          pkt_done_q, pkt_done_d;

   logic          push;
   logic          pop;
   logic [31:0]   head;

   assign wr.wr_ready = (count_q != CW'(DEPTH));
   assign push        = wr.wr_valid && wr.wr_ready;
   assign head        = fifo_mem[rd_ptr_q];

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      bit_cnt_d  = bit_cnt_q;
      gap_cnt_d  = gap_cnt_q;
      dout_d     = dout_q;
      valido_n_d = valido_n_q;
      frameo_n_d = frameo_n_q;
      pkt_done_d = 1'b0;
      pop        = 1'b0;

      case (state_q)
         IDLE: begin
            pop = (count_q != '0);
         end
         SHIFT: begin
            if (bit_cnt_q == 5'd31) begin
               state_d    = GAP;
               gap_cnt_d  = GW'(MIN_GAP);
               dout_d     = 1'b0;
               valido_n_d = 1'b1;
               frameo_n_d = 1'b1;
            end else begin
               bit_cnt_d  = bit_cnt_q + 5'd1;
               shreg_d    = {1'b0, shreg_q[30:1]};
               dout_d     = shreg_q[0];
               frameo_n_d = (bit_cnt_q == 5'd30);
               pkt_done_d = (bit_cnt_q == 5'd30);
            end
         end
         GAP: begin
            if (gap_cnt_q == GW'(1)) begin
               if (count_q != '0) begin
                  pop = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q - GW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A pop always starts a new packet with bit 0 on the pins.
      if (pop) begin
         state_d    = SHIFT;
         shreg_d    = head[31:1];
         bit_cnt_d  = 5'd0;
         dout_d     = head[0];
         valido_n_d = 1'b0;
         frameo_n_d = 1'b0;
      end
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= wr.wr_data;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         bit_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         dout_q     <= 1'b0;
         valido_n_q <= 1'b1;
         frameo_n_q <= 1'b1;
         pkt_done_q <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         shreg_q    <= shreg_d;
         bit_cnt_q  <= bit_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         dout_q     <= dout_d;
         valido_n_q <= valido_n_d;
         frameo_n_q <= frameo_n_d;
         pkt_done_q <= pkt_done_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   assign dout       = dout_q;
   assign valido_n   = valido_n_q;
   assign frameo_n   = frameo_n_q;
   assign pkt_done   = pkt_done_q;
   assign fifo_count = count_q;
   assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_router_port_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_router_port_tx : directed bench for router_port_tx, MIN_GAP=1 and MIN_GAP=5 (rev 1.0)
// ---------------------------------------------------------------------------
module tb_router_port_tx;
   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]       wv = '0;
   logic [1:0][31:0] wd = '0;
   logic [1:0]       wrdy, dout, valido_n, frameo_n, pkt_done, busy;
   logic [1:0][2:0]  cnt;

   router_port_tx_if bus0 ();
   router_port_tx_if bus1 ();

   assign bus0.wr_valid = wv[0];
   assign bus0.wr_data  = wd[0];
   assign wrdy[0]       = bus0.wr_ready;
   assign bus1.wr_valid = wv[1];
   assign bus1.wr_data  = wd[1];
   assign wrdy[1]       = bus1.wr_ready;

   router_port_tx #(.DEPTH(4), .MIN_GAP(1)) dut0 (
      .clock(clock), .reset_n(reset_n), .wr(bus0),
      .dout(dout[0]), .valido_n(valido_n[0]), .frameo_n(frameo_n[0]),
      .pkt_done(pkt_done[0]), .busy(busy[0]), .fifo_count(cnt[0]));

   router_port_tx #(.DEPTH(4), .MIN_GAP(5)) dut1 (
      .clock(clock), .reset_n(reset_n), .wr(bus1),
      .dout(dout[1]), .valido_n(valido_n[1]), .frameo_n(frameo_n[1]),
      .pkt_done(pkt_done[1]), .busy(busy[1]), .fifo_count(cnt[1]));

   int total = 0;
   int bad   = 0;

   // Serial receiver: rebuilds words, records idle run and occupancy at each bit 0.
   int          in_pkt[2]    = '{0, 0};
   int          bitpos[2]    = '{0, 0};
   int          cur_bit[2]   = '{0, 0};
   int          idle_run[2]  = '{0, 0};
   int          seen[2]      = '{0, 0};
   int          rx_n[2]      = '{0, 0};
   int          proto_bad[2] = '{0, 0};
   int          pd_cnt[2]    = '{0, 0};
   int          act_cnt[2]   = '{0, 0};
   logic [31:0] rx_sh[2];
   logic [31:0] rx_word[2][32];
   int          gap_len[2][32];
   logic [2:0]  b0cnt[2][32];

   always @(negedge clock or negedge reset_n) begin
      for (int p = 0; p < 2; p++) begin
         if (!reset_n) begin
            in_pkt[p]   = 0;
            seen[p]     = 0;
            idle_run[p] = 0;
         end else if (valido_n[p] == 1'b0) begin
            act_cnt[p]++;
            if (in_pkt[p] == 0) begin
               in_pkt[p] = 1;
               bitpos[p] = 0;
               if (rx_n[p] < 32) begin
                  gap_len[p][rx_n[p]] = (seen[p] != 0) ? idle_run[p] : -1;
                  b0cnt[p][rx_n[p]]   = cnt[p];
               end
            end
            cur_bit[p] = bitpos[p];
            rx_sh[p][bitpos[p]] = dout[p];
            if (pkt_done[p] !== frameo_n[p]) proto_bad[p]++;
            if (frameo_n[p] == 1'b1) begin
               if (bitpos[p] != 31) proto_bad[p]++;
               if (pkt_done[p] == 1'b1) pd_cnt[p]++;
               if (rx_n[p] < 32) rx_word[p][rx_n[p]] = rx_sh[p];
               rx_n[p]++;
               in_pkt[p]   = 0;
               seen[p]     = 1;
               idle_run[p] = 0;
            end else begin
               if (bitpos[p] == 31) proto_bad[p]++;
               else bitpos[p]++;
            end
         end else begin
            if (dout[p] !== 1'b0 || frameo_n[p] !== 1'b1 || pkt_done[p] !== 1'b0) proto_bad[p]++;
            if (in_pkt[p] != 0) begin
               proto_bad[p]++;
               in_pkt[p] = 0;
            end
            idle_run[p]++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic smp();
      @(negedge clock);
      #1;
   endtask

   task automatic push(input int p, input logic [31:0] w);
      int k = 0;
      wv[p] = 1'b1;
      wd[p] = w;
      while (!wrdy[p] && k < 2000) begin
         step();
         k++;
      end
      step();
      wv[p] = 1'b0;
      chk("push_timeout", 32'(k < 2000), 1);
   endtask

   task automatic wait_rx(input int p, input int n);
      int k = 0;
      while (rx_n[p] < n && k < 2000) begin
         smp();
         k++;
      end
      chk("rx_timeout", 32'(rx_n[p] >= n), 1);
   endtask

   task automatic wait_idle(input int p);
      int k = 0;
      while (busy[p] && k < 2000) begin
         smp();
         k++;
      end
      chk("idle_timeout", 32'(k < 2000), 1);
   endtask

   initial begin
      int          base;
      int          idx;
      int          a;
      int          k;
      logic        acc;
      logic [31:0] bp [8];

      // Reset state
      smp();
      chk("rst_dout", dout[0], 0);
      chk("rst_valido_n", valido_n[0], 1);
      chk("rst_frameo_n", frameo_n[0], 1);
      chk("rst_pkt_done", pkt_done[0], 0);
      chk("rst_count", cnt[0], 0);
      chk("rst_busy", busy[0], 0);
      step();
      reset_n = 1'b1;
      chk("rst_wr_ready", wrdy, 2'b11);

      // Single word: written at edge T, bit 0 after T+1
      push(0, 32'hdead_beef);
      chk("t1_count_after_write", cnt[0], 1);
      chk("t1_not_yet_valid", valido_n[0], 1);
      step();
      chk("t1_bit0_dout", dout[0], 1);
      chk("t1_bit0_valido_n", valido_n[0], 0);
      chk("t1_bit0_frameo_n", frameo_n[0], 0);
      chk("t1_count_popped", cnt[0], 0);
      chk("t1_busy", busy[0], 1);
      wait_rx(0, 1);
      chk("t1_bit31_frameo_n", frameo_n[0], 1);
      chk("t1_bit31_valido_n", valido_n[0], 0);
      chk("t1_bit31_pkt_done", pkt_done[0], 1);
      chk("t1_word", rx_word[0][0], 32'hdead_beef);
      chk("t1_pkt_done_pulses", pd_cnt[0], 1);
      smp();
      chk("t1_gap_valido_n", valido_n[0], 1);
      chk("t1_gap_busy", busy[0], 1);
      smp();
      chk("t1_after_gap_busy", busy[0], 0);

      // Back-to-back with MIN_GAP=1
      push(0, 32'h1234_1234);
      push(0, 32'h0000_1111);
      wait_rx(0, 3);
      chk("t2_word0", rx_word[0][1], 32'h1234_1234);
      chk("t2_word1", rx_word[0][2], 32'h0000_1111);
      chk("t2_gap", gap_len[0][2], 1);
      wait_idle(0);

      // Push on the edge where GAP pops, with two words queued
      push(0, 32'h0f0f_0f0f);
      push(0, 32'h8000_0001);
      push(0, 32'h7fff_fffe);
      chk("t3_count_queued", cnt[0], 2);
      k = 0;
      while (!(valido_n[0] == 1'b0 && frameo_n[0] == 1'b1) && k < 200) begin
         smp();
         k++;
      end
      chk("t3_bit31_reach", 32'(k < 200), 1);
      step();
      chk("t3_gap_valido_n", valido_n[0], 1);
      chk("t3_gap_count", cnt[0], 2);
      wv[0] = 1'b1;
      wd[0] = 32'hcafe_f00d;
      step();
      wv[0] = 1'b0;
      chk("t3_simul_count", cnt[0], 2);
      chk("t3_next_valido_n", valido_n[0], 0);
      chk("t3_next_bit0", dout[0], 1);
      wait_rx(0, 7);
      chk("t3_word_a", rx_word[0][3], 32'h0f0f_0f0f);
      chk("t3_word_b", rx_word[0][4], 32'h8000_0001);
      chk("t3_word_c", rx_word[0][5], 32'h7fff_fffe);
      chk("t3_word_d", rx_word[0][6], 32'hcafe_f00d);
      wait_idle(0);

      // Backpressure: wr_valid held 8 cycles
      base = rx_n[0];
      for (int i = 0; i < 8; i++) bp[i] = 32'h9000_0000 ^ (32'(i) * 32'h1357_9bdf);
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         wv[0] = 1'b1;
         wd[0] = bp[idx];
         acc   = wrdy[0];
         step();
         if (acc) idx++;
      end
      wv[0] = 1'b0;
      chk("t4_accepted", idx, 5);
      chk("t4_wr_ready_full", wrdy[0], 0);
      chk("t4_count_full", cnt[0], 4);
      for (int i = 5; i < 8; i++) begin
         push(0, bp[i]);
         chk("t4_drain_accept", rx_n[0] - base, i - 4);
      end
      wait_rx(0, base + 8);
      for (int i = 0; i < 8; i++) chk("t4_order", rx_word[0][base + i], bp[i]);
      wait_idle(0);
      repeat (40) smp();
      chk("t4_no_dup", rx_n[0], base + 8);
      chk("p0_protocol", proto_bad[0], 0);

      // Long gap on the MIN_GAP=5 port
      push(1, 32'h0000_0003);
      push(1, 32'haaaa_5555);
      push(1, 32'h0123_4567);
      push(1, 32'hfedc_ba98);
      chk("t6_count_queued", cnt[1], 3);
      wait_rx(1, 4);
      chk("t6_word1", rx_word[1][1], 32'haaaa_5555);
      chk("t6_word2", rx_word[1][2], 32'h0123_4567);
      chk("t6_word3", rx_word[1][3], 32'hfedc_ba98);
      for (int i = 1; i < 4; i++) begin
         chk("t6_gap", gap_len[1][i], 5);
         chk("t6_count_at_bit0", b0cnt[1][i], 3'(3 - i));
      end
      wait_idle(1);
      chk("p1_protocol", proto_bad[1], 0);

      // Reset during bit 10 with two words queued
      push(0, 32'h1111_2222);
      push(0, 32'h3333_4444);
      push(0, 32'h5555_6666);
      chk("t5_count_queued", cnt[0], 2);
      k = 0;
      while (!(in_pkt[0] == 1 && cur_bit[0] == 10) && k < 200) begin
         smp();
         k++;
      end
      chk("t5_bit10_reach", 32'(k < 200), 1);
      reset_n = 1'b0;
      #1;
      chk("t5_rst_valido_n", valido_n[0], 1);
      chk("t5_rst_frameo_n", frameo_n[0], 1);
      chk("t5_rst_dout", dout[0], 0);
      chk("t5_rst_count", cnt[0], 0);
      chk("t5_rst_busy", busy[0], 0);
      step();
      reset_n = 1'b1;
      chk("t5_wr_ready", wrdy[0], 1);
      a = act_cnt[0];
      repeat (50) smp();
      chk("t5_no_activity", act_cnt[0], a);
      chk("t5_still_empty", cnt[0], 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
